// File: rtl/uart_apb_echo_master.sv
// APB master that enables the UART, polls STATUS and echoes every received byte
// back through TXDATA via a small FIFO. Optional macro: UART_ECHO_UPCASE_EN (upcase a..z on push).
module uart_apb_echo_master #(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int unsigned POLL_GAP   = 4
) (
   input  logic                        PCLK,
   input  logic                        PRESET,
   input  logic                        run,
   output logic [31:0]                 PADDR,
   output logic                        PSEL,
   output logic                        PENABLE,
   output logic                        PWRITE,
   output logic [31:0]                 PWDATA,
   input  logic [31:0]                 PRDATA,
   input  logic                        PREADY,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic [7:0]                  err_count,
   output logic [7:0]                  drop_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

   localparam logic [31:0] OFS_CTRL   = 32'h0000_0000;
   localparam logic [31:0] OFS_STATUS = 32'h0000_0004;
   localparam logic [31:0] OFS_TXDATA = 32'h0000_0008;
   localparam logic [31:0] OFS_RXDATA = 32'h0000_000C;

   typedef enum logic [2:0] {INIT_WR, POLL_RD, DECIDE, RX_RD, TX_WR, GAP} state_t;
   typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_ACCESS} phase_t;

   state_t state_q, state_d;
   phase_t phase_q, phase_d;

   logic          tx_busy_q, rx_valid_q, rx_err_q;
   logic [GW-1:0] gap_cnt;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count_q;
   logic          fifo_full, fifo_empty, done;

   logic          load, write_d, cap_status, push, pop, err_inc, drop_inc;
   logic [31:0]   addr_d, wdata_d;
   logic [7:0]    push_byte;

   logic          unused_prdata;
   assign unused_prdata = ^PRDATA[31:8];

   function automatic logic [7:0] echo_byte(input logic [7:0] b);
`ifdef UART_ECHO_UPCASE_EN
      if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
      return b;
   endfunction

   assign PSEL       = (phase_q != PH_IDLE);
   assign PENABLE    = (phase_q == PH_ACCESS);
   assign done       = (phase_q == PH_ACCESS) && PREADY;
   assign fifo_full  = (count_q == FULL_CNT);
   assign fifo_empty = (count_q == '0);
   assign fifo_count = count_q;
   assign push_byte  = echo_byte(PRDATA[7:0]);

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q <= INIT_WR;
         phase_q <= PH_IDLE;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
      end
   end

   // Each transfer state walks IDLE -> SETUP -> ACCESS; RX/TX enter at SETUP
   // because DECIDE already provides the idle cycle after the STATUS read.
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      load       = 1'b0;
      addr_d     = '0;
      write_d    = 1'b0;
      wdata_d    = '0;
      cap_status = 1'b0;
      push       = 1'b0;
      pop        = 1'b0;
      err_inc    = 1'b0;
      drop_inc   = 1'b0;
      if (phase_q == PH_SETUP) phase_d = PH_ACCESS;
      case (state_q)
         INIT_WR: begin
            if (phase_q == PH_IDLE) begin
               phase_d = PH_SETUP;
               load    = 1'b1;
               addr_d  = BASE_ADDR + OFS_CTRL;
               write_d = 1'b1;
               wdata_d = 32'h0000_0003;
            end else if (done) begin
               state_d = POLL_RD;
               phase_d = PH_IDLE;
            end
         end
         POLL_RD: begin
            if (phase_q == PH_IDLE) begin
               if (run) begin
                  phase_d = PH_SETUP;
                  load    = 1'b1;
                  addr_d  = BASE_ADDR + OFS_STATUS;
               end
            end else if (done) begin
               cap_status = 1'b1;
               state_d    = DECIDE;
               phase_d    = PH_IDLE;
            end
         end
         DECIDE: begin
            if (rx_valid_q) begin
               state_d = RX_RD;
               phase_d = PH_SETUP;
               load    = 1'b1;
               addr_d  = BASE_ADDR + OFS_RXDATA;
            end else if (!fifo_empty && !tx_busy_q) begin
               state_d = TX_WR;
               phase_d = PH_SETUP;
               load    = 1'b1;
               addr_d  = BASE_ADDR + OFS_TXDATA;
               write_d = 1'b1;
               wdata_d = {24'h0, mem[rd_ptr]};
            end else if (POLL_GAP == 0) begin
               state_d = POLL_RD;
            end else begin
               state_d = GAP;
            end
         end
         RX_RD: begin
            if (done) begin
               if (rx_err_q)       err_inc  = 1'b1;
               else if (fifo_full) drop_inc = 1'b1;
               else                push     = 1'b1;
               state_d = POLL_RD;
               phase_d = PH_IDLE;
            end
         end
         TX_WR: begin
            if (done) begin
               pop     = 1'b1;
               state_d = POLL_RD;
               phase_d = PH_IDLE;
            end
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) state_d = POLL_RD;
         end
         default: begin
            state_d = INIT_WR;
            phase_d = PH_IDLE;
         end
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         PADDR      <= '0;
         PWRITE     <= 1'b0;
         PWDATA     <= '0;
         tx_busy_q  <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_err_q   <= 1'b0;
         gap_cnt    <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         err_count  <= '0;
         drop_count <= '0;
      end else begin
         if (load) begin
            PADDR  <= addr_d;
            PWRITE <= write_d;
            PWDATA <= wdata_d;
         end
         if (cap_status) begin
            tx_busy_q  <= PRDATA[0];
            rx_valid_q <= PRDATA[3];
            rx_err_q   <= PRDATA[4];
         end
         gap_cnt <= (state_q == GAP) ? gap_cnt + 1'b1 : '0;
         if (push) begin
            wr_ptr  <= wr_ptr + 1'b1;
            count_q <= count_q + 1'b1;
         end
         if (pop) begin
            rd_ptr  <= rd_ptr + 1'b1;
            count_q <= count_q - 1'b1;
         end
         if (err_inc && err_count != 8'hFF)   err_count  <= err_count + 8'd1;
         if (drop_inc && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
   end

   always_ff @(posedge PCLK) begin
      if (push) mem[wr_ptr] <= push_byte;
   end

endmodule

// File: tb/tb_uart_apb_echo_master.sv
// Bench for uart_apb_echo_master: behavioural UART slave at negedge, scoreboard of
// expected TXDATA bytes. Honours UART_ECHO_UPCASE_EN for its expectations.
`timescale 1ns/1ps
module tb_uart_apb_echo_master;

   logic        PCLK = 1'b0;
   logic        PRESET = 1'b1;
   logic        run = 1'b0;
   logic [31:0] PADDR, PWDATA;
   logic        PSEL, PENABLE, PWRITE;
   logic [31:0] PRDATA = 32'h0;
   logic        PREADY = 1'b1;
   logic [3:0]  fifo_count;
   logic [7:0]  err_count, drop_count;

   uart_apb_echo_master #(.FIFO_DEPTH(8), .BASE_ADDR(32'h0000_0000), .POLL_GAP(4)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .run(run),
      .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY),
      .fifo_count(fifo_count), .err_count(err_count), .drop_count(drop_count));

   always #5 PCLK = ~PCLK;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] data;
   } xfer_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [7:0]  rxq[$];
   bit          rxe[$];
   logic [7:0]  exp_q[$];
   xfer_t       obs_q[$];
   bit          tx_busy = 1'b0;
   int          stall_next = 0;
   int          stall_left = 0;
   int          poll_cnt = 0;

   function automatic logic [7:0] model_echo(input logic [7:0] b);
`ifdef UART_ECHO_UPCASE_EN
      if (b inside {[8'h61:8'h7A]}) return b ^ 8'h20;
`endif
      return b;
   endfunction

   // UART slave model; logs every completed non-STATUS transfer into obs_q.
   always @(negedge PCLK) begin
      if (PRESET) begin
         stall_left = 0;
         PREADY = 1'b1;
      end else if (PSEL && !PENABLE) begin
         if (PADDR == 32'h4 && stall_next > 0) begin
            stall_left = stall_next;
            stall_next = 0;
         end
      end else if (PSEL && PENABLE) begin
         if (stall_left > 0) begin
            stall_left--;
            PREADY = 1'b0;
            PRDATA = 32'hFFFF_FFFF;
         end else begin
            PREADY = 1'b1;
            PRDATA = 32'h0;
            if (!PWRITE && PADDR == 32'h4) begin
               PRDATA = {27'd0, (rxq.size() > 0) ? rxe[0] : 1'b0, rxq.size() > 0, 2'b00, tx_busy};
               poll_cnt++;
            end else begin
               if (!PWRITE && PADDR == 32'hC && rxq.size() > 0) begin
                  PRDATA = {24'hA5A5A5, rxq.pop_front()};
                  rxe.delete(0);
               end
               obs_q.push_back('{addr: PADDR, wr: PWRITE, data: PWRITE ? PWDATA : PRDATA});
            end
         end
      end
   end

   task automatic wait_obs(output xfer_t t, output bit ok);
      ok = 1'b0;
      t.addr = '0; t.wr = 1'b0; t.data = '0;
      for (int i = 0; i < 300; i++) begin
         if (obs_q.size() > 0) begin
            t = obs_q.pop_front();
            ok = 1'b1;
            return;
         end
         @(negedge PCLK); #1;
      end
   endtask

   task automatic test_reset();
      xfer_t t; bit ok;
      PRESET = 1'b1; run = 1'b1; obs_q.delete();
      repeat (3) @(negedge PCLK);
      n_cmp++; if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin n_bad++; $display("FAIL rst_ctl: got %b expected 000", {PSEL, PENABLE, PWRITE}); end
      n_cmp++; if (PADDR !== 32'h0) begin n_bad++; $display("FAIL rst_paddr: got %h expected 0", PADDR); end
      n_cmp++; if (PWDATA !== 32'h0) begin n_bad++; $display("FAIL rst_pwdata: got %h expected 0", PWDATA); end
      n_cmp++; if ({fifo_count, err_count, drop_count} !== 20'h0) begin n_bad++; $display("FAIL rst_counts: got %h expected 0", {fifo_count, err_count, drop_count}); end
      @(posedge PCLK); #1 PRESET = 1'b0;
      @(negedge PCLK);
      n_cmp++; if (PSEL !== 1'b0) begin n_bad++; $display("FAIL init_cyc1_psel: got %b expected 0", PSEL); end
      @(negedge PCLK);
      n_cmp++; if ({PSEL, PENABLE, PWRITE} !== 3'b101) begin n_bad++; $display("FAIL init_setup: got %b expected 101", {PSEL, PENABLE, PWRITE}); end
      n_cmp++; if ({PADDR, PWDATA} !== {32'h0, 32'h3}) begin n_bad++; $display("FAIL init_setup_addr_data: got %h expected %h", {PADDR, PWDATA}, {32'h0, 32'h3}); end
      @(negedge PCLK);
      n_cmp++; if ({PSEL, PENABLE, PADDR} !== {2'b11, 32'h0}) begin n_bad++; $display("FAIL init_access: got %h expected %h", {PSEL, PENABLE, PADDR}, {2'b11, 32'h0}); end
      @(negedge PCLK);
      n_cmp++; if ({PSEL, PENABLE} !== 2'b00) begin n_bad++; $display("FAIL init_idle_after: got %b expected 00", {PSEL, PENABLE}); end
      wait_obs(t, ok);
      n_cmp++; if (!ok || {t.addr, t.wr, t.data} !== {32'h0, 1'b1, 32'h3}) begin n_bad++; $display("FAIL init_xfer: got ok=%b %h expected %h", ok, {t.addr, t.wr, t.data}, {32'h0, 1'b1, 32'h3}); end
   endtask

   task automatic test_echo();
      xfer_t t; bit ok; logic [7:0] e;
      rxq.push_back(8'hA5); rxe.push_back(1'b0); exp_q.push_back(model_echo(8'hA5));
      wait_obs(t, ok);
      n_cmp++; if (!ok || {t.addr, t.wr} !== {32'hC, 1'b0}) begin n_bad++; $display("FAIL echo_rxread: got ok=%b %h expected %h", ok, {t.addr, t.wr}, {32'hC, 1'b0}); end
      @(negedge PCLK);
      n_cmp++; if (fifo_count !== 4'd1) begin n_bad++; $display("FAIL echo_count1: got %0d expected 1", fifo_count); end
      wait_obs(t, ok);
      e = exp_q.pop_front();
      n_cmp++; if (!ok || {t.addr, t.wr, t.data} !== {32'h8, 1'b1, 24'h0, e}) begin n_bad++; $display("FAIL echo_txwrite: got ok=%b %h expected %h", ok, {t.addr, t.wr, t.data}, {32'h8, 1'b1, 24'h0, e}); end
      @(negedge PCLK);
      n_cmp++; if (fifo_count !== 4'd0) begin n_bad++; $display("FAIL echo_count0: got %0d expected 0", fifo_count); end
   endtask

   task automatic test_rx_err();
      xfer_t t; bit ok;
      rxq.push_back(8'h3C); rxe.push_back(1'b1);
      wait_obs(t, ok);
      n_cmp++; if (!ok || {t.addr, t.wr} !== {32'hC, 1'b0}) begin n_bad++; $display("FAIL err_rxread: got ok=%b %h expected %h", ok, {t.addr, t.wr}, {32'hC, 1'b0}); end
      @(negedge PCLK);
      n_cmp++; if ({err_count, fifo_count} !== {8'd1, 4'd0}) begin n_bad++; $display("FAIL err_counts: got %h expected %h", {err_count, fifo_count}, {8'd1, 4'd0}); end
      repeat (40) @(negedge PCLK);
      n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL err_no_tx: got %0d transfers expected 0", obs_q.size()); end
   endtask

   task automatic test_fifo_full();
      xfer_t t; bit ok; logic [7:0] e;
      tx_busy = 1'b1;
      for (int i = 0; i < 9; i++) begin
         rxq.push_back((i == 8) ? 8'hEE : 8'h30 + 8'(i)); rxe.push_back(1'b0);
         if (i < 8) exp_q.push_back(model_echo(8'h30 + 8'(i)));
      end
      for (int i = 0; i < 9; i++) begin
         wait_obs(t, ok);
         n_cmp++; if (!ok || {t.addr, t.wr} !== {32'hC, 1'b0}) begin n_bad++; $display("FAIL full_rxread%0d: got ok=%b %h expected %h", i, ok, {t.addr, t.wr}, {32'hC, 1'b0}); end
      end
      @(negedge PCLK);
      n_cmp++; if ({fifo_count, drop_count, err_count} !== {4'd8, 8'd1, 8'd1}) begin n_bad++; $display("FAIL full_counts: got %h expected %h", {fifo_count, drop_count, err_count}, {4'd8, 8'd1, 8'd1}); end
      tx_busy = 1'b0;
      for (int i = 0; i < 8; i++) begin
         wait_obs(t, ok);
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
         n_cmp++; if (!ok || {t.addr, t.wr, t.data} !== {32'h8, 1'b1, 24'h0, e}) begin n_bad++; $display("FAIL full_tx%0d: got ok=%b %h expected %h", i, ok, {t.addr, t.wr, t.data}, {32'h8, 1'b1, 24'h0, e}); end
      end
      @(negedge PCLK);
      n_cmp++; if (fifo_count !== 4'd0) begin n_bad++; $display("FAIL full_drained: got %0d expected 0", fifo_count); end
   endtask

   task automatic test_wait_states();
      int cnt; int p0; bit stable; bit found;
      stall_next = 5; found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge PCLK); #1;
         if (PSEL && !PENABLE && PADDR == 32'h4) found = 1'b1;
      end
      cnt = 0; stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge PCLK); #1;
         if (!(PSEL && PENABLE)) break;
         cnt++;
         if (PADDR !== 32'h4 || PWRITE !== 1'b0) stable = 1'b0;
      end
      n_cmp++; if (!found || cnt != 6) begin n_bad++; $display("FAIL wait_access_cycles: got found=%b %0d expected 6", found, cnt); end
      n_cmp++; if (!stable) begin n_bad++; $display("FAIL wait_addr_stable: got unstable expected stable"); end
      p0 = poll_cnt;
      repeat (30) @(negedge PCLK);
      n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL wait_no_early_sample: got %0d transfers expected 0", obs_q.size()); end
      n_cmp++; if (poll_cnt <= p0) begin n_bad++; $display("FAIL wait_polling_resumed: got %0d polls expected > %0d", poll_cnt, p0); end
   endtask

   task automatic test_run_park();
      xfer_t t; bit ok; int cnt; logic [7:0] e;
      run = 1'b0;
      repeat (12) @(negedge PCLK);
      cnt = 0;
      rxq.push_back(8'h5A); rxe.push_back(1'b0); exp_q.push_back(model_echo(8'h5A));
      for (int i = 0; i < 20; i++) begin
         @(negedge PCLK);
         if (PSEL) cnt++;
      end
      n_cmp++; if (cnt != 0 || obs_q.size() != 0) begin n_bad++; $display("FAIL park_idle: got %0d psel cycles %0d transfers expected 0", cnt, obs_q.size()); end
      run = 1'b1;
      wait_obs(t, ok);
      n_cmp++; if (!ok || {t.addr, t.wr} !== {32'hC, 1'b0}) begin n_bad++; $display("FAIL park_resume_rx: got ok=%b %h expected %h", ok, {t.addr, t.wr}, {32'hC, 1'b0}); end
      wait_obs(t, ok);
      e = exp_q.pop_front();
      n_cmp++; if (!ok || {t.addr, t.wr, t.data} !== {32'h8, 1'b1, 24'h0, e}) begin n_bad++; $display("FAIL park_resume_tx: got ok=%b %h expected %h", ok, {t.addr, t.wr, t.data}, {32'h8, 1'b1, 24'h0, e}); end
   endtask

   task automatic test_reset_mid();
      xfer_t t; bit ok; bit found;
      tx_busy = 1'b1;
      rxq.push_back(8'h11); rxe.push_back(1'b0);
      rxq.push_back(8'h22); rxe.push_back(1'b0);
      for (int i = 0; i < 2; i++) wait_obs(t, ok);
      @(negedge PCLK);
      n_cmp++; if (fifo_count !== 4'd2) begin n_bad++; $display("FAIL rstmid_filled: got %0d expected 2", fifo_count); end
      stall_next = 3; found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge PCLK); #1;
         if (PSEL && !PENABLE && PADDR == 32'h4) found = 1'b1;
      end
      @(negedge PCLK); #1;
      n_cmp++; if (!found || {PSEL, PENABLE} !== 2'b11) begin n_bad++; $display("FAIL rstmid_in_access: got found=%b %b expected 11", found, {PSEL, PENABLE}); end
      PRESET = 1'b1;
      @(negedge PCLK);
      n_cmp++; if ({PSEL, PENABLE} !== 2'b00) begin n_bad++; $display("FAIL rstmid_psel_drop: got %b expected 00", {PSEL, PENABLE}); end
      n_cmp++; if ({fifo_count, err_count, drop_count} !== 20'h0) begin n_bad++; $display("FAIL rstmid_counts: got %h expected 0", {fifo_count, err_count, drop_count}); end
      obs_q.delete(); tx_busy = 1'b0;
      @(posedge PCLK); #1 PRESET = 1'b0;
      wait_obs(t, ok);
      n_cmp++; if (!ok || {t.addr, t.wr, t.data} !== {32'h0, 1'b1, 32'h3}) begin n_bad++; $display("FAIL rstmid_init_again: got ok=%b %h expected %h", ok, {t.addr, t.wr, t.data}, {32'h0, 1'b1, 32'h3}); end
      repeat (40) @(negedge PCLK);
      n_cmp++; if (obs_q.size() !== 0 || fifo_count !== 4'd0) begin n_bad++; $display("FAIL rstmid_flushed: got %0d transfers count %0d expected 0 0", obs_q.size(), fifo_count); end
   endtask

   task automatic test_upcase();
      xfer_t t; bit ok; int n_rx; int n_tx; logic [7:0] e;
      logic [7:0] bytes [3] = '{8'h61, 8'h7B, 8'h41};
      for (int i = 0; i < 3; i++) begin
         rxq.push_back(bytes[i]); rxe.push_back(1'b0); exp_q.push_back(model_echo(bytes[i]));
      end
      n_rx = 0; n_tx = 0;
      for (int i = 0; i < 6 && n_tx < 3; i++) begin
         wait_obs(t, ok);
         if (ok && t.addr == 32'hC && !t.wr) n_rx++;
         else begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            n_tx++;
            n_cmp++; if (!ok || {t.addr, t.wr, t.data} !== {32'h8, 1'b1, 24'h0, e}) begin n_bad++; $display("FAIL case_tx%0d: got ok=%b %h expected %h", n_tx, ok, {t.addr, t.wr, t.data}, {32'h8, 1'b1, 24'h0, e}); end
         end
      end
      n_cmp++; if (n_rx != 3 || n_tx != 3) begin n_bad++; $display("FAIL case_xfer_counts: got rx=%0d tx=%0d expected 3 3", n_rx, n_tx); end
   endtask

   initial begin
      test_reset();
      test_echo();
      test_rx_err();
      test_fifo_full();
      test_wait_states();
      test_run_park();
      test_reset_mid();
      test_upcase();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
